quiz_fluxo_dados: RTL and testbench

QUIZ_FLUXO_DADOS -- requirements
Module: quiz_fluxo_dados

---
 rtl/quiz_fluxo_dados.sv | 143 ++++++++++++++
 tb/tb_quiz_fluxo_dados.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_fluxo_dados.sv
// Quiz game datapath: answer table, round/hit/index counters, answer registers
// and a button-press edge detector, all driven by strobes from an external FSM.
module quiz_fluxo_dados #(
  parameter int N_RODADAS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       zeraR,
  input  logic       zeraRod,
  input  logic       zeraA,
  input  logic       zeraM,
  input  logic       zeraI,
  input  logic       registraR,
  input  logic       registraM,
  input  logic       contaRod,
  input  logic       contaA,
  input  logic       contaI,
  output logic       jogada_feita,
  output logic       botaoIgualMemoria,
  output logic       rodadaIgualFinal,
  output logic [3:0] db_rodada,
  output logic [3:0] db_acertos,
  output logic [3:0] db_jogada,
  output logic [3:0] db_resposta,
  output logic [3:0] db_indice
);

  localparam logic [3:0] ULTIMA_RODADA = 4'(N_RODADAS - 1);

  logic [3:0] r_indice;
  logic [3:0] r_rodada;
  logic [3:0] r_acertos;
  logic [3:0] r_jogada;
  logic [3:0] r_resposta;
  logic       r_botaoAnt;
  logic       r_esperaSoltar;
  logic       r_jogadaFeita;

  logic [3:0] w_endereco;
  logic [3:0] w_saidaTabela;
  logic       w_algumBotao;

  assign w_algumBotao = |botoes;
  assign w_endereco   = r_indice + r_rodada;

  always_comb begin
    w_saidaTabela = 4'h0;
    case (w_endereco)
      4'd0:  w_saidaTabela = 4'h1;
      4'd1:  w_saidaTabela = 4'h2;
      4'd2:  w_saidaTabela = 4'h4;
      4'd3:  w_saidaTabela = 4'h8;
      4'd4:  w_saidaTabela = 4'h2;
      4'd5:  w_saidaTabela = 4'h8;
      4'd6:  w_saidaTabela = 4'h1;
      4'd7:  w_saidaTabela = 4'h4;
      4'd8:  w_saidaTabela = 4'h4;
      4'd9:  w_saidaTabela = 4'h1;
      4'd10: w_saidaTabela = 4'h8;
      4'd11: w_saidaTabela = 4'h2;
      4'd12: w_saidaTabela = 4'h8;
      4'd13: w_saidaTabela = 4'h4;
      4'd14: w_saidaTabela = 4'h2;
      4'd15: w_saidaTabela = 4'h1;
      default: w_saidaTabela = 4'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_indice <= 4'd0;
    end else if (zeraI) begin
      r_indice <= 4'd0;
    end else if (contaI) begin
      r_indice <= r_indice + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rodada <= 4'd0;
    end else if (zeraRod) begin
      r_rodada <= 4'd0;
    end else if (contaRod) begin
      r_rodada <= (r_rodada == ULTIMA_RODADA) ? 4'd0 : r_rodada + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acertos <= 4'd0;
    end else if (zeraA) begin
      r_acertos <= 4'd0;
    end else if (contaA && r_acertos != 4'hF) begin
      r_acertos <= r_acertos + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_jogada <= 4'd0;
    end else if (zeraR) begin
      r_jogada <= 4'd0;
    end else if (registraR) begin
      r_jogada <= botoes;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_resposta <= 4'd0;
    end else if (zeraM) begin
      r_resposta <= 4'd0;
    end else if (registraM) begin
      r_resposta <= w_saidaTabela;
    end
  end

  // r_esperaSoltar remembers a button held during reset so that no press is
  // reported until all buttons have been released at least once.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_botaoAnt     <= 1'b0;
      r_jogadaFeita  <= 1'b0;
      r_esperaSoltar <= w_algumBotao;
    end else begin
      r_botaoAnt     <= w_algumBotao;
      r_jogadaFeita  <= w_algumBotao & ~r_botaoAnt & ~r_esperaSoltar;
      r_esperaSoltar <= r_esperaSoltar & w_algumBotao;
    end
  end

  assign jogada_feita      = r_jogadaFeita;
  assign botaoIgualMemoria = (r_jogada == r_resposta) && (r_jogada != 4'd0);
  assign rodadaIgualFinal  = (r_rodada == ULTIMA_RODADA);
  assign db_rodada         = r_rodada;
  assign db_acertos        = r_acertos;
  assign db_jogada         = r_jogada;
  assign db_resposta       = r_resposta;
  assign db_indice         = r_indice;

endmodule

// File: tb/tb_quiz_fluxo_dados.sv
// Self-checking bench for quiz_fluxo_dados: reference model feeds a scoreboard
// queue of expected outputs, compared one clock after each stimulus step.
module tb_quiz_fluxo_dados;

  localparam int N = 10;

  logic       clock;
  logic       reset;
  logic [3:0] botoes;
  logic       zeraR, zeraRod, zeraA, zeraM, zeraI;
  logic       registraR, registraM;
  logic       contaRod, contaA, contaI;
  logic       jogada_feita, botaoIgualMemoria, rodadaIgualFinal;
  logic [3:0] db_rodada, db_acertos, db_jogada, db_resposta, db_indice;

  quiz_fluxo_dados #(.N_RODADAS(N)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraR(zeraR), .zeraRod(zeraRod), .zeraA(zeraA), .zeraM(zeraM), .zeraI(zeraI),
    .registraR(registraR), .registraM(registraM),
    .contaRod(contaRod), .contaA(contaA), .contaI(contaI),
    .jogada_feita(jogada_feita), .botaoIgualMemoria(botaoIgualMemoria),
    .rodadaIgualFinal(rodadaIgualFinal),
    .db_rodada(db_rodada), .db_acertos(db_acertos), .db_jogada(db_jogada),
    .db_resposta(db_resposta), .db_indice(db_indice)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] rod, ac, jog, resp, ind;
    logic       jf, igual, fim;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  logic [3:0] tabela [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h2, 4'h8, 4'h1, 4'h4,
                              4'h4, 4'h1, 4'h8, 4'h2, 4'h8, 4'h4, 4'h2, 4'h1};

  logic [3:0] mRod, mAc, mJog, mResp, mInd;
  logic       mAnt, mEspera, mJf;
  int         pulsos;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clearStrobes();
    zeraR = 0; zeraRod = 0; zeraA = 0; zeraM = 0; zeraI = 0;
    registraR = 0; registraM = 0; contaRod = 0; contaA = 0; contaI = 0;
  endtask

  task automatic compareScoreboard();
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput("sbEmpty", 8'd1, 8'd0);
      return;
    end
    e = sbq.pop_front();
    checkOutput("rodada",   {4'd0, db_rodada},   {4'd0, e.rod});
    checkOutput("acertos",  {4'd0, db_acertos},  {4'd0, e.ac});
    checkOutput("jogada",   {4'd0, db_jogada},   {4'd0, e.jog});
    checkOutput("resposta", {4'd0, db_resposta}, {4'd0, e.resp});
    checkOutput("indice",   {4'd0, db_indice},   {4'd0, e.ind});
    checkOutput("jogFeita", {7'd0, jogada_feita},      {7'd0, e.jf});
    checkOutput("igual",    {7'd0, botaoIgualMemoria}, {7'd0, e.igual});
    checkOutput("final",    {7'd0, rodadaIgualFinal},  {7'd0, e.fim});
  endtask

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic applyStimulus();
    exp_t e;
    logic [3:0] tabOut;
    logic       algum;
    tabOut = tabela[4'(mInd + mRod)];
    algum  = |botoes;
    if (!reset) begin
      mRod = 0; mAc = 0; mJog = 0; mResp = 0; mInd = 0;
      mAnt = 0; mJf = 0; mEspera = algum;
    end else begin
      mJf     = algum && !mAnt && !mEspera;
      mAnt    = algum;
      mEspera = mEspera && algum;
      if (zeraI) mInd = 0; else if (contaI) mInd = mInd + 4'd1;
      if (zeraRod) mRod = 0;
      else if (contaRod) mRod = (int'(mRod) == N - 1) ? 4'd0 : mRod + 4'd1;
      if (zeraA) mAc = 0; else if (contaA && mAc < 4'd15) mAc = mAc + 4'd1;
      if (zeraR) mJog = 0; else if (registraR) mJog = botoes;
      if (zeraM) mResp = 0; else if (registraM) mResp = tabOut;
    end
    e.rod = mRod; e.ac = mAc; e.jog = mJog; e.resp = mResp; e.ind = mInd;
    e.jf = mJf; e.igual = (mJog == mResp) && (mJog != 0); e.fim = (int'(mRod) == N - 1);
    sbq.push_back(e);
    @(posedge clock);
    #1;
    if (jogada_feita) pulsos++;
    compareScoreboard();
  endtask

  initial begin
    reset = 0; botoes = 0; pulsos = 0;
    clearStrobes();
    @(negedge clock);

    // Reset for two cycles, then idle
    applyStimulus();
    applyStimulus();
    reset = 1;
    applyStimulus();
    checkOutput("rstIdx", {4'd0, db_indice}, 8'd0);

    // Index to 3 then load expected answer
    contaI = 1;
    repeat (3) applyStimulus();
    contaI = 0; registraM = 1;
    applyStimulus();
    registraM = 0;
    checkOutput("idx3", {4'd0, db_indice}, 8'd3);
    checkOutput("resp8", {4'd0, db_resposta}, 8'h8);

    // Press button 8 for four cycles, register on the pulse cycle
    pulsos = 0;
    botoes = 4'h8;
    applyStimulus();
    registraR = jogada_feita;
    applyStimulus();
    registraR = 0;
    applyStimulus();
    applyStimulus();
    botoes = 0;
    checkOutput("onePulse", 8'(pulsos), 8'd1);
    checkOutput("jog8", {4'd0, db_jogada}, 8'h8);
    checkOutput("igual1", {7'd0, botaoIgualMemoria}, 8'd1);
    contaA = 1;
    applyStimulus();
    contaA = 0;
    checkOutput("acert1", {4'd0, db_acertos}, 8'd1);

    // Second button while one is held gives no new pulse
    botoes = 4'h1;
    applyStimulus();
    pulsos = 0;
    botoes = 4'h3;
    applyStimulus();
    applyStimulus();
    botoes = 0;
    applyStimulus();
    checkOutput("noPulse2nd", 8'(pulsos), 8'd0);

    // Round counter reaches the last round and wraps
    zeraRod = 1; applyStimulus(); zeraRod = 0;
    contaRod = 1;
    repeat (9) applyStimulus();
    contaRod = 0;
    checkOutput("rod9", {4'd0, db_rodada}, 8'd9);
    checkOutput("fim1", {7'd0, rodadaIgualFinal}, 8'd1);
    contaRod = 1; applyStimulus(); contaRod = 0;
    checkOutput("rodWrap", {4'd0, db_rodada}, 8'd0);
    checkOutput("fim0", {7'd0, rodadaIgualFinal}, 8'd0);

    // Hit counter saturation and clear priority
    contaA = 1;
    repeat (20) applyStimulus();
    checkOutput("acSat", {4'd0, db_acertos}, 8'd15);
    zeraA = 1;
    applyStimulus();
    zeraA = 0; contaA = 0;
    checkOutput("acZera", {4'd0, db_acertos}, 8'd0);

    // Mid-game reset with buttons held and strobes active
    contaRod = 1; contaA = 1;
    repeat (4) applyStimulus();
    contaA = 0;
    applyStimulus();
    contaRod = 0;
    checkOutput("rod5", {4'd0, db_rodada}, 8'd5);
    checkOutput("ac4", {4'd0, db_acertos}, 8'd4);
    botoes = 4'h2;
    applyStimulus();
    reset = 0; contaRod = 1; contaA = 1; contaI = 1; registraR = 1; registraM = 1;
    applyStimulus();
    clearStrobes();
    checkOutput("rstRod", {4'd0, db_rodada}, 8'd0);
    checkOutput("rstAc", {4'd0, db_acertos}, 8'd0);
    reset = 1;
    pulsos = 0;
    repeat (3) applyStimulus();
    checkOutput("heldNoPulse", 8'(pulsos), 8'd0);
    botoes = 0;
    applyStimulus();
    botoes = 4'h4;
    applyStimulus();
    checkOutput("rePress", {7'd0, jogada_feita}, 8'd1);
    botoes = 0;
    applyStimulus();

    // Random strobes and buttons against the model
    for (int i = 0; i < 60; i++) begin
      botoes    = 4'($urandom_range(0, 15));
      zeraR     = ($urandom_range(0, 9) == 0);
      zeraRod   = ($urandom_range(0, 9) == 0);
      zeraA     = ($urandom_range(0, 9) == 0);
      zeraM     = ($urandom_range(0, 9) == 0);
      zeraI     = ($urandom_range(0, 9) == 0);
      registraR = $urandom_range(0, 1) == 1;
      registraM = $urandom_range(0, 1) == 1;
      contaRod  = $urandom_range(0, 1) == 1;
      contaA    = $urandom_range(0, 1) == 1;
      contaI    = $urandom_range(0, 1) == 1;
      reset     = ($urandom_range(0, 19) != 0);
      applyStimulus();
    end
    clearStrobes();
    reset = 1;

    checkOutput("sbDrained", 8'(sbq.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
